// File: rtl/inst_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch slice.
package inst_fetch_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   INST_ADDR_W  = 32;
  localparam int   INST_W       = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Word-align a byte address; the low two bits never reach the PC.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM-side and decode-side signals of the fetch stage, bundled for port lists.
interface inst_fetch_if #(
  parameter int ADDR_W = 6
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              branch_flag;
  logic [31:0]       branch_target;
  logic              id_ready;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_inst;

  modport master (
    output rom_ce, rom_addr, if_valid, if_pc, if_inst,
    input  rom_inst, branch_flag, branch_target, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, if_valid, if_pc, if_inst,
    output rom_inst, branch_flag, branch_target, id_ready
  );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter and ROM chip enable: start-up, hold, +4 advance and redirect.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int                     ADDR_W   = 6,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   advance,
  input  logic                   redirect,
  input  logic [INST_ADDR_W-1:0] target,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0]      rom_addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      rom_ce <= CHIP_DISABLE;
      pc     <= RESET_PC;
    end else if (start) begin
      rom_ce <= CHIP_ENABLE;
      pc     <= RESET_PC;
    end else if (redirect) begin
      pc <= word_align(target);
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

  // Word address wraps every 256 bytes of PC; that aliasing is intended.
  assign rom_addr = pc[ADDR_W+1:2];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC/ROM control plus registered IF/ID output with
// valid/ready back-pressure and branch flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                     ADDR_W   = 6,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  fetch_state_e             state_q, state_d;
  logic                     start, capture, redirect, out_free;
  logic                     rom_ce_w;
  logic [INST_ADDR_W-1:0]   pc_w;
  logic [ADDR_W-1:0]        rom_addr_w;
  logic                     vld_p1;
  logic [INST_ADDR_W-1:0]   pc_p1;
  logic [INST_W-1:0]        inst_p1;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .advance  (capture),
    .redirect (redirect),
    .target   (bus.branch_target),
    .rom_ce   (rom_ce_w),
    .pc       (pc_w),
    .rom_addr (rom_addr_w)
  );

  assign out_free = !vld_p1 || bus.id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // HOLD differs from FETCH only in name: in both, a free output slot
  // captures the instruction already presented by the ROM at pc.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    capture  = 1'b0;
    redirect = 1'b0;
    unique case (state_q)
      IDLE: begin
        start   = 1'b1;
        state_d = FETCH;
      end
      FETCH, HOLD: begin
        if (bus.branch_flag) begin
          redirect = 1'b1;
          state_d  = FETCH;
        end else if (out_free) begin
          capture = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: IF/ID output register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      vld_p1  <= 1'b0;
      pc_p1   <= ZERO_WORD;
      inst_p1 <= ZERO_WORD;
    end else if (redirect) begin
      vld_p1 <= 1'b0;
    end else if (capture) begin
      vld_p1  <= 1'b1;
      pc_p1   <= pc_w;
      inst_p1 <= bus.rom_inst;
    end
  end

  assign bus.rom_ce   = rom_ce_w;
  assign bus.rom_addr = rom_addr_w;
  assign bus.if_valid = vld_p1;
  assign bus.if_pc    = pc_p1;
  assign bus.if_inst  = inst_p1;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios then randomized
// back-pressure and redirects against a program-order reference stream.
module tb_inst_fetch;

  localparam int          ADDR_W   = 6;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom [64];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic        held_valid = 1'b0;
  logic [31:0] held_pc, held_inst, mon_e;

  inst_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_inst = bus.rom_ce ? rom[bus.rom_addr] : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: after reset or a redirect, decode must receive instructions in
  // program order starting from the given byte address.
  task automatic restart(input logic [31:0] start_pc);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start_pc + 32'(4 * i));
  endtask

  function automatic logic [31:0] rom_at(input logic [31:0] byte_addr);
    return rom[byte_addr[7:2]];
  endfunction

  // Monitor: transfers and hold-stability judged at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (held_valid) begin
          chk("hold_valid", 32'(bus.if_valid), 32'd1);
          chk("hold_pc", bus.if_pc, held_pc);
          chk("hold_inst", bus.if_inst, held_inst);
        end
        if (bus.if_valid && bus.id_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_empty: got pc %h, expected no transfer", bus.if_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("xfer_pc", bus.if_pc, mon_e);
            chk("xfer_inst", bus.if_inst, rom_at(mon_e));
            n_xfer++;
          end
        end
        held_valid = bus.if_valid && !bus.id_ready && !bus.branch_flag;
        held_pc    = bus.if_pc;
        held_inst  = bus.if_inst;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic br;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h3401_1100;
    rom[1] = 32'h3402_0020;
    rom[2] = 32'h3403_FF00;
    rom[3] = 32'h3404_FFFF;
    rst = 1'b0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'h0;
    bus.id_ready      = 1'b0;

    // Reset state
    #12;
    chk("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'(RESET_PC[7:2]));

    // Start-up and streaming
    @(posedge clk); #1;
    rst = 1'b1;
    bus.id_ready = 1'b1;
    restart(RESET_PC);
    step();
    chk("e1_rom_ce", 32'(bus.rom_ce), 32'd1);
    chk("e1_if_valid", 32'(bus.if_valid), 32'd0);
    step();
    chk("e2_if_valid", 32'(bus.if_valid), 32'd1);
    chk("e2_if_pc", bus.if_pc, 32'h0);
    chk("e2_if_inst", bus.if_inst, 32'h3401_1100);
    step();
    chk("e3_if_pc", bus.if_pc, 32'h4);

    // Stall for three cycles on pc 0x4
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.if_pc, 32'h4);
      chk("stall_inst", bus.if_inst, 32'h3402_0020);
    end
    bus.id_ready = 1'b1;
    step();
    chk("resume_pc", bus.if_pc, 32'h8);
    chk("resume_inst", bus.if_inst, 32'h3403_FF00);

    // Redirect while stalled, unaligned target
    bus.id_ready      = 1'b0;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h23;
    step();
    bus.branch_flag = 1'b0;
    restart(32'h20);
    chk("br_if_valid", 32'(bus.if_valid), 32'd0);
    chk("br_rom_addr", 32'(bus.rom_addr), 32'd8);
    step();
    chk("br_out_valid", 32'(bus.if_valid), 32'd1);
    chk("br_out_pc", bus.if_pc, 32'h20);
    chk("br_out_inst", bus.if_inst, rom[8]);
    bus.id_ready = 1'b1;

    // ROM word-address wrap
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'hF8;
    step();
    bus.branch_flag = 1'b0;
    restart(32'hF8);
    chk("wrap_addr0", 32'(bus.rom_addr), 32'd62);
    step();
    chk("wrap_pc0", bus.if_pc, 32'hF8);
    chk("wrap_addr1", 32'(bus.rom_addr), 32'd63);
    step();
    chk("wrap_pc1", bus.if_pc, 32'hFC);
    chk("wrap_addr2", 32'(bus.rom_addr), 32'd0);
    step();
    chk("wrap_pc2", bus.if_pc, 32'h100);
    chk("wrap_inst2", bus.if_inst, rom[0]);

    // Asynchronous reset between edges, then branch ignored in IDLE
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("arst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("arst_if_pc", bus.if_pc, 32'h0);
    chk("arst_if_inst", bus.if_inst, 32'h0);
    restart(RESET_PC);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.branch_flag = 1'b0;
    chk("idle_br_rom_ce", 32'(bus.rom_ce), 32'd1);
    chk("idle_br_rom_addr", 32'(bus.rom_addr), 32'(RESET_PC[7:2]));
    step();
    chk("idle_br_valid", 32'(bus.if_valid), 32'd1);
    chk("idle_br_pc", bus.if_pc, RESET_PC);
    chk("idle_br_inst", bus.if_inst, rom_at(RESET_PC));

    // Randomized back-pressure and redirects
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.id_ready    = ($urandom % 4) != 0;
      br              = ($urandom % 16) == 0;
      bus.branch_flag = br;
      if (br) bus.branch_target = $urandom;
      step();
      if (br) begin
        bus.branch_flag = 1'b0;
        restart(bus.branch_target & ~32'h3);
      end
    end
    bus.id_ready    = 1'b1;
    bus.branch_flag = 1'b0;
    repeat (4) step();
    chk("xfer_progress", 32'(n_xfer > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
